// File: rtl/mem_lsu_wb.sv
// MEM-stage load/store unit: handshaked data-memory access, load alignment/extension, MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing.
module mem_lsu_wb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] mem_alu_result_i,
  input  logic [31:0] mem_busB_i,
  input  logic [4:0]  mem_Rw_i,
  input  logic        mem_RegWr_i,
  input  logic [1:0]  mem_MemWr_i,
  input  logic        mem_MemtoReg_i,
  input  logic [1:0]  mem_MemRead_i,
  output logic        mem_stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        wb_RegWr_o,
  output logic [4:0]  wb_Rw_o,
  output logic        wb_MemtoReg_o,
  output logic [31:0] wb_alu_result_o,
  output logic [31:0] wb_mem_data_o,
  output logic        mem_err_o
);

  typedef enum logic [0:0] {IDLE, BUSY} state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic        req_q, we_q, is_load_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  rsize_q, rlane_q;

  logic        wr_op, rd_op, mem_op, trap_c, timeout_hit;
  logic [1:0]  size_c, lane_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ext_c;
  logic        stall_c, err_c, issue_c, kill_c, load_data_c;

  assign wr_op  = |mem_MemWr_i;
  assign rd_op  = |mem_MemRead_i;
  assign mem_op = wr_op | rd_op;
  // A store takes priority over a simultaneous load request.
  assign size_c = wr_op ? mem_MemWr_i : mem_MemRead_i;
  assign lane_c = mem_alu_result_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_c = ((size_c == 2'b10) && lane_c[0]) || ((size_c == 2'b11) && (lane_c != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = mem_busB_i;
    case (size_c)
      2'b01: begin
        be_c    = 4'b0001 << lane_c;
        wdata_c = {4{mem_busB_i[7:0]}};
      end
      2'b10: begin
        be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_busB_i[15:0]}};
      end
      2'b11: be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  always_comb begin
    ext_c = dmem_rdata_i;
    case (rsize_q)
      2'b01: begin
        case (rlane_q)
          2'd0:    ext_c = {{24{dmem_rdata_i[7]}},  dmem_rdata_i[7:0]};
          2'd1:    ext_c = {{24{dmem_rdata_i[15]}}, dmem_rdata_i[15:8]};
          2'd2:    ext_c = {{24{dmem_rdata_i[23]}}, dmem_rdata_i[23:16]};
          default: ext_c = {{24{dmem_rdata_i[31]}}, dmem_rdata_i[31:24]};
        endcase
      end
      2'b10: ext_c = rlane_q[1] ? {{16{dmem_rdata_i[31]}}, dmem_rdata_i[31:16]}
                                : {{16{dmem_rdata_i[15]}}, dmem_rdata_i[15:0]};
      default: ext_c = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stall_c     = 1'b0;
    err_c       = 1'b0;
    issue_c     = 1'b0;
    kill_c      = 1'b0;
    load_data_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && trap_c) begin
          err_c  = 1'b1;
          kill_c = 1'b1;
        end else if (mem_op) begin
          stall_c = 1'b1;
          issue_c = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ready_i) begin
          load_data_c = is_load_q;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          err_c   = 1'b1;
          kill_c  = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      is_load_q       <= 1'b0;
      be_q            <= 4'b0000;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      rsize_q         <= 2'b00;
      rlane_q         <= 2'b00;
      wb_RegWr_o      <= 1'b0;
      wb_Rw_o         <= 5'd0;
      wb_MemtoReg_o   <= 1'b0;
      wb_alu_result_o <= 32'h0;
      wb_mem_data_o   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (issue_c) begin
        req_q     <= 1'b1;
        we_q      <= wr_op;
        is_load_q <= ~wr_op;
        be_q      <= be_c;
        addr_q    <= {mem_alu_result_i[31:2], 2'b00};
        wdata_q   <= wdata_c;
        rsize_q   <= size_c;
        rlane_q   <= lane_c;
        cnt_q     <= '0;
      end else if (state_q == BUSY) begin
        if (state_d == IDLE) req_q <= 1'b0;
        else                 cnt_q <= cnt_q + CW'(1);
      end
      // A stalled cycle retires nothing, so write-back sees a bubble.
      wb_Rw_o         <= mem_Rw_i;
      wb_alu_result_o <= mem_alu_result_i;
      if (stall_c) begin
        wb_RegWr_o    <= 1'b0;
        wb_MemtoReg_o <= 1'b0;
      end else begin
        wb_RegWr_o    <= mem_RegWr_i & ~kill_c;
        wb_MemtoReg_o <= mem_MemtoReg_i;
      end
      if (load_data_c) wb_mem_data_o <= ext_c;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  // Combinational outputs are gated so they read 0 while reset is held.
  assign mem_stall_o  = stall_c & rst_n_i;
  assign mem_err_o    = err_c & rst_n_i;

endmodule

// File: tb/tb_mem_lsu_wb.sv
// Scoreboard bench for mem_lsu_wb: driver pushes expected request/write-back records, a negedge monitor checks them.
module tb_mem_lsu_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_alu_result, mem_busB, dmem_rdata;
  logic [4:0]  mem_Rw;
  logic        mem_RegWr, mem_MemtoReg, dmem_ready;
  logic [1:0]  mem_MemWr, mem_MemRead;
  logic        mem_stall, dmem_req, dmem_we, wb_RegWr, wb_MemtoReg, mem_err;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, wb_alu_result, wb_mem_data;
  logic [4:0]  wb_Rw;

  always #5 clk = ~clk;

  mem_lsu_wb #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .mem_alu_result_i(mem_alu_result), .mem_busB_i(mem_busB), .mem_Rw_i(mem_Rw),
    .mem_RegWr_i(mem_RegWr), .mem_MemWr_i(mem_MemWr), .mem_MemtoReg_i(mem_MemtoReg),
    .mem_MemRead_i(mem_MemRead), .mem_stall_o(mem_stall), .dmem_req_o(dmem_req),
    .dmem_we_o(dmem_we), .dmem_be_o(dmem_be), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata), .dmem_ready_i(dmem_ready),
    .wb_RegWr_o(wb_RegWr), .wb_Rw_o(wb_Rw), .wb_MemtoReg_o(wb_MemtoReg),
    .wb_alu_result_o(wb_alu_result), .wb_mem_data_o(wb_mem_data), .mem_err_o(mem_err)
  );

  typedef struct {
    int          stalls;
    bit          err;
    bit          regwr;
    logic [4:0]  rw;
    bit          mtr;
    logic [31:0] alu;
    logic [31:0] mdata;
  } wb_exp_t;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t rq_q[$];
  wb_exp_t  e;
  req_exp_t r;
  int checks = 0;
  int failures = 0;
  bit active = 1'b0;
  int stall_cnt, req_cnt;
  bit pend, err_seen, req_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a cycle with mem_stall low retires one instruction into WB on the next edge.
  always @(negedge clk) begin
    if (!active) begin
      pend = 0; stall_cnt = 0; req_cnt = 0; req_prev = 0; err_seen = 0;
    end else begin
      if (pend) begin
        if (wb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wb_unexpected: got a retirement expected none");
        end else begin
          e = wb_q.pop_front();
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("req_cycles", req_cnt, e.stalls);
          chk("mem_err", {31'd0, err_seen}, {31'd0, e.err});
          chk("wb_RegWr", {31'd0, wb_RegWr}, {31'd0, e.regwr});
          chk("wb_Rw", {27'd0, wb_Rw}, {27'd0, e.rw});
          chk("wb_MemtoReg", {31'd0, wb_MemtoReg}, {31'd0, e.mtr});
          chk("wb_alu_result", wb_alu_result, e.alu);
          chk("wb_mem_data", wb_mem_data, e.mdata);
          $display("wb retire rw=%0d regwr=%0d mdata=0x%08h err=%0d stalls=%0d",
                   wb_Rw, wb_RegWr, wb_mem_data, err_seen, stall_cnt);
        end
        pend = 0; stall_cnt = 0; req_cnt = 0;
      end
      if (dmem_req && !req_prev) begin
        if (rq_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL req_unexpected: got addr 0x%08h expected no request", dmem_addr);
        end else begin
          r = rq_q.pop_front();
          chk("dmem_we", {31'd0, dmem_we}, {31'd0, r.we});
          chk("dmem_be", {28'd0, dmem_be}, {28'd0, r.be});
          chk("dmem_addr", dmem_addr, r.addr);
          if (r.we) chk("dmem_wdata", dmem_wdata, r.wdata);
        end
      end
      req_prev = dmem_req;
      if (dmem_req) req_cnt++;
      if (mem_stall) stall_cnt++;
      else begin
        pend = 1;
        err_seen = mem_err;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the retiring edge.
  task automatic issue(input logic [1:0] wr, input logic [1:0] rd, input logic [31:0] addr,
                       input logic [31:0] busb, input logic [4:0] rw, input bit regwr, input bit mtr,
                       input int rdy_after, input logic [31:0] rdata,
                       input bit ereq, input logic [3:0] ebe, input logic [31:0] ewdata,
                       input int estalls, input bit eerr, input bit eregwr, input logic [31:0] emdata);
    wb_exp_t  we_rec;
    req_exp_t rq_rec;
    int busy = 0;
    int guard = 0;
    bit done = 0;
    we_rec.stalls = estalls; we_rec.err = eerr; we_rec.regwr = eregwr; we_rec.rw = rw;
    we_rec.mtr = mtr; we_rec.alu = addr; we_rec.mdata = emdata;
    wb_q.push_back(we_rec);
    if (ereq) begin
      rq_rec.we = (wr != 2'b00); rq_rec.be = ebe;
      rq_rec.addr = {addr[31:2], 2'b00}; rq_rec.wdata = ewdata;
      rq_q.push_back(rq_rec);
    end
    mem_MemWr = wr; mem_MemRead = rd; mem_alu_result = addr; mem_busB = busb;
    mem_Rw = rw; mem_RegWr = regwr; mem_MemtoReg = mtr;
    while (!done) begin
      if (dmem_req) begin
        busy++;
        dmem_ready = (rdy_after != 0) && (busy == rdy_after);
        dmem_rdata = dmem_ready ? rdata : 32'h5A5A5A5A;
      end else begin
        dmem_ready = 1'b0;
      end
      @(negedge clk);
      if (!mem_stall) done = 1;
      else if (++guard > 40) begin
        checks++; failures++;
        $display("FAIL stall_bound: got stall after %0d cycles expected release", guard);
        done = 1;
      end
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
  endtask

  task automatic idle_inputs();
    mem_MemWr = 2'b00; mem_MemRead = 2'b00; mem_alu_result = 32'h0; mem_busB = 32'h0;
    mem_Rw = 5'd0; mem_RegWr = 1'b0; mem_MemtoReg = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wb_RegWr", {31'd0, wb_RegWr}, 32'd0);
    chk("rst_wb_mem_data", wb_mem_data, 32'h0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    active = 1'b1;
    //     wr    rd    addr          busB          rw  rg mt rdy rdata         req be    wdata         st er rw  mdata
    issue(2'd0, 2'd0, 32'h12345678, 32'h0,        5,  1, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 1, 32'h0);
    issue(2'd3, 2'd0, 32'h10,       32'hDEADBEEF, 0,  0, 0, 4, 32'h0,        1, 4'hF, 32'hDEADBEEF, 4, 0, 0, 32'h0);
    issue(2'd0, 2'd1, 32'h13,       32'h0,        7,  1, 1, 1, 32'h80FF0000, 1, 4'h8, 32'h0,        1, 0, 1, 32'hFFFFFF80);
    issue(2'd0, 2'd2, 32'h12,       32'h0,        8,  1, 1, 1, 32'h7ABC1234, 1, 4'hC, 32'h0,        1, 0, 1, 32'h00007ABC);
    issue(2'd2, 2'd0, 32'h12,       32'h0000BEEF, 0,  0, 0, 2, 32'h0,        1, 4'hC, 32'hBEEFBEEF, 2, 0, 0, 32'h00007ABC);
    issue(2'd0, 2'd2, 32'h20,       32'h0,        9,  1, 1, 1, 32'h12348001, 1, 4'h3, 32'h0,        1, 0, 1, 32'hFFFF8001);
    issue(2'd1, 2'd0, 32'h21,       32'h000000A5, 0,  0, 0, 1, 32'h0,        1, 4'h2, 32'hA5A5A5A5, 1, 0, 0, 32'hFFFF8001);
    issue(2'd0, 2'd1, 32'h21,       32'h0,        10, 1, 1, 1, 32'h00007F00, 1, 4'h2, 32'h0,        1, 0, 1, 32'h0000007F);
    issue(2'd0, 2'd3, 32'h24,       32'h0,        11, 1, 1, 3, 32'hCAFEF00D, 1, 4'hF, 32'h0,        3, 0, 1, 32'hCAFEF00D);
    issue(2'd3, 2'd3, 32'h28,       32'h11223344, 9,  1, 0, 1, 32'hFFFFFFFF, 1, 4'hF, 32'h11223344, 1, 0, 1, 32'hCAFEF00D);
    issue(2'd0, 2'd3, 32'h30,       32'h0,        10, 1, 1, 0, 32'h0,        1, 4'hF, 32'h0,        4, 1, 0, 32'hCAFEF00D);
    issue(2'd0, 2'd0, 32'h0000A5A5, 32'h0,        3,  1, 1, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 1, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
    issue(2'd0, 2'd3, 32'h11,       32'h0,        14, 1, 1, 1, 32'h01020304, 0, 4'h0, 32'h0,        0, 1, 0, 32'hCAFEF00D);
    issue(2'd0, 2'd2, 32'h13,       32'h0,        15, 1, 1, 1, 32'h89AB0000, 0, 4'h0, 32'h0,        0, 1, 0, 32'hCAFEF00D);
`else
    issue(2'd0, 2'd3, 32'h11,       32'h0,        14, 1, 1, 1, 32'h01020304, 1, 4'hF, 32'h0,        1, 0, 1, 32'h01020304);
    issue(2'd0, 2'd2, 32'h13,       32'h0,        15, 1, 1, 1, 32'h89AB0000, 1, 4'hC, 32'h0,        1, 0, 1, 32'hFFFF89AB);
`endif
    idle_inputs();
    @(negedge clk); #1;
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("req_queue_drained", rq_q.size(), 32'd0);
    active = 1'b0;

    // Asynchronous reset in the middle of a load.
    @(posedge clk); #1;
    mem_MemRead = 2'd3; mem_alu_result = 32'h40; mem_Rw = 5'd12; mem_RegWr = 1'b1;
    @(posedge clk); #1;
    chk("busy_dmem_req", {31'd0, dmem_req}, 32'd1);
    chk("busy_mem_stall", {31'd0, mem_stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("arst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("arst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("arst_wb_Rw", {27'd0, wb_Rw}, 32'd0);
    chk("arst_wb_alu_result", wb_alu_result, 32'h0);
    chk("arst_wb_mem_data", wb_mem_data, 32'h0);
    chk("arst_mem_err", {31'd0, mem_err}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    active = 1'b1;
    issue(2'd0, 2'd0, 32'h0BADF00D, 32'h0, 6,  1, 0, 0, 32'h0,        0, 4'h0, 32'h0, 0, 0, 1, 32'h0);
    issue(2'd0, 2'd3, 32'h44,       32'h0, 13, 1, 1, 1, 32'h13572468, 1, 4'hF, 32'h0, 1, 0, 1, 32'h13572468);
    idle_inputs();
    @(negedge clk); #1;
    chk("wb_queue_final", wb_q.size(), 32'd0);
    chk("req_queue_final", rq_q.size(), 32'd0);
    active = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
